// File: rtl/alu_issue_queue_pkg.sv
// Shared types and constants for the ALU issue queue: widths, opcode set and
// the queue entry layout.
package alu_issue_queue_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned NUM_OPS = 6;

  localparam logic [OP_W-1:0] OP_0 = 4'd0;
  localparam logic [OP_W-1:0] OP_1 = 4'd1;
  localparam logic [OP_W-1:0] OP_2 = 4'd2;
  localparam logic [OP_W-1:0] OP_3 = 4'd3;
  localparam logic [OP_W-1:0] OP_4 = 4'd4;
  localparam logic [OP_W-1:0] OP_5 = 4'd5;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } iq_entry_t;

endpackage

// File: rtl/alu_issue_queue_fifo.sv
// Circular buffer of queue entries with power-of-two depth; pointers wrap
// naturally at DEPTH.
module alu_op_fifo
  import alu_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  iq_entry_t push_data,
  input  logic      pop,
  output iq_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  iq_entry_t        mem_q [DEPTH];
  iq_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Issue stage in front of the pipelined ALU: buffers ops, drops illegal
// opcodes, issues one op per cycle and tags the returning results.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 2,
  parameter int unsigned NUM_OPS = alu_issue_queue_pkg::NUM_OPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [OP_W-1:0]   in_op,
  output logic              err_illegal,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_vld,
  input  logic [DATA_W-1:0] alu_res,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [DATA_W-1:0] res_tag,
  output logic              idle
);

  iq_entry_t in_entry, head;
  logic      full, empty, accept, legal, push, pop;

  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              alu_vld_q, alu_vld_d;
  logic [DATA_W-1:0] alu_tag_q, alu_tag_d;
  logic [DATA_W-1:0] tag_q, tag_d;
  logic              err_q, err_d;

  // {valid, tag} travels beside the ALU's internal pipe, one stage per latency edge
  logic [ALU_LAT-1:0]             pipe_vld_q, pipe_vld_d;
  logic [ALU_LAT-1:0][DATA_W-1:0] pipe_tag_q, pipe_tag_d;

  alu_op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(in_entry),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    in_entry = '{a: in_a, b: in_b, op: in_op};
    accept   = in_valid & ~full;
    legal    = (32'(in_op) < NUM_OPS);
    push     = accept & legal;
    pop      = ~empty;

    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = '0;
    alu_vld_d = pop;
    alu_tag_d = alu_tag_q;
    tag_d     = tag_q;
    err_d     = accept & ~legal;
    if (pop) begin
      alu_a_d   = head.a;
      alu_b_d   = head.b;
      alu_op_d  = head.op;
      alu_tag_d = tag_q;
      tag_d     = tag_q + 1'b1;
    end

    pipe_vld_d    = pipe_vld_q;
    pipe_tag_d    = pipe_tag_q;
    pipe_vld_d[0] = alu_vld_q;
    pipe_tag_d[0] = alu_tag_q;
    for (int unsigned i = 1; i < ALU_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      alu_vld_q  <= 1'b0;
      alu_tag_q  <= '0;
      tag_q      <= '0;
      err_q      <= 1'b0;
      pipe_vld_q <= '0;
      pipe_tag_q <= '0;
    end else begin
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      alu_vld_q  <= alu_vld_d;
      alu_tag_q  <= alu_tag_d;
      tag_q      <= tag_d;
      err_q      <= err_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_tag_q <= pipe_tag_d;
    end
  end

  assign in_ready    = ~full;
  assign err_illegal = err_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign alu_vld     = alu_vld_q;
  assign res_valid   = pipe_vld_q[ALU_LAT-1];
  assign res_data    = res_valid ? alu_res : '0;
  assign res_tag     = pipe_tag_q[ALU_LAT-1];
  // An issued op counts as in flight from the moment it sits on alu_*
  assign idle        = empty & ~alu_vld_q & ~(|pipe_vld_q);

endmodule
